// File: rtl/proc_run_controller.sv
// Run controller for a processor under test: holds the processor in reset,
// releases it at a chosen PC, and watches for the end PC or a watchdog expiry.
module proc_run_controller #(
  parameter int          RESET_CYCLES = 2,
  parameter logic [15:0] WATCHDOG_MAX = 16'h00FF
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] start_pc_in,
  input  logic [63:0] end_pc,
  input  logic [63:0] expected,
  input  logic [63:0] currentpc,
  input  logic [63:0] MemtoRegOut,
  output logic        proc_reset,
  output logic [63:0] startpc,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [7:0]  run_count,
  output logic [7:0]  pass_count
);

  localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_t;

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic [15:0]   watchdog;
  logic [63:0]   end_pc_q;
  logic [63:0]   expected_q;
  logic          end_hit;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic en);
    return (en && (v != 8'hFF)) ? v + 8'd1 : v;
  endfunction

  // Unsigned compare: a PC with bit 63 set is a large address, not a negative one.
  assign end_hit    = (currentpc >= end_pc_q);
  assign proc_reset = reset | (state == HOLD);

  // Run targets are pure data; they are only meaningful once a start captures them.
  always_ff @(posedge CLK) begin
    if (state == IDLE && start) begin
      end_pc_q   <= end_pc;
      expected_q <= expected;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      startpc    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      run_count  <= '0;
      pass_count <= '0;
      watchdog   <= '0;
      hold_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            startpc  <= start_pc_in;
            pass     <= 1'b0;
            timeout  <= 1'b0;
            hold_cnt <= '0;
            busy     <= 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            watchdog <= '0;
            state    <= RUN;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: begin
          // End-PC detection wins over the watchdog on the same cycle.
          if (end_hit) begin
            pass    <= (MemtoRegOut == expected_q);
            timeout <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else if (watchdog == WATCHDOG_MAX) begin
            pass    <= 1'b0;
            timeout <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            watchdog <= watchdog + 16'd1;
          end
        end
        DONE: begin
          done       <= 1'b0;
          busy       <= 1'b0;
          run_count  <= sat_inc(run_count, 1'b1);
          pass_count <= sat_inc(pass_count, pass);
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_run_controller.sv
// Randomized scoreboard bench for proc_run_controller: a run-level reference
// model predicts each run's outcome; a monitor checks every done pulse.
module tb_proc_run_controller;

  localparam int RC     = 2;
  localparam int WD_MAX = 255;

  logic        CLK = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] start_pc_in, end_pc, expected, currentpc, MemtoRegOut;
  logic        proc_reset, busy, done, pass, timeout;
  logic [63:0] startpc;
  logic [7:0]  run_count, pass_count;

  proc_run_controller #(.RESET_CYCLES(RC), .WATCHDOG_MAX(16'(WD_MAX))) dut (
    .CLK(CLK), .reset(reset), .start(start), .start_pc_in(start_pc_in),
    .end_pc(end_pc), .expected(expected), .currentpc(currentpc),
    .MemtoRegOut(MemtoRegOut), .proc_reset(proc_reset), .startpc(startpc),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .run_count(run_count), .pass_count(pass_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    longint unsigned done_cyc;
    bit              pass;
    bit              to;
    logic [63:0]     spc;
    int              rc;
    int              pc;
  } exp_t;

  exp_t            sbq[$];
  int              checks = 0;
  int              fails  = 0;
  longint unsigned cyc    = 0;
  int              m_rc   = 0;
  int              m_pc   = 0;
  logic [63:0]     cur_base = '0, cur_step = '0, cur_salt = '0;
  bit              pm_first = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Processor stand-in: sits at its entry PC while held in reset, then steps.
  always @(negedge CLK) begin
    if (proc_reset) begin
      currentpc = cur_base;
      pm_first  = 1'b1;
    end else if (pm_first) begin
      pm_first = 1'b0;
    end else begin
      currentpc = currentpc + cur_step;
    end
    MemtoRegOut = currentpc ^ cur_salt;
  end

  // Reference: the PC on RUN cycle n is base + step*(n-1); the run ends at the
  // first such PC >= end, or times out after WD_MAX+1 cycles without one.
  function automatic void predict(input logic [63:0] base, input logic [63:0] step,
                                  input logic [63:0] endp, output int k,
                                  output logic [63:0] pck, output bit to);
    logic [63:0] p;
    to  = 1'b1;
    k   = WD_MAX + 1;
    pck = '0;
    for (int n = 1; n <= WD_MAX + 1; n++) begin
      p = base + step * 64'(n - 1);
      if (p >= endp) begin
        k   = n;
        pck = p;
        to  = 1'b0;
        break;
      end
    end
  endfunction

  function automatic int sat8(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic run_one(input logic [63:0] base, input logic [63:0] step,
                         input logic [63:0] endp, input logic [63:0] expv,
                         input logic [63:0] salt, input bit use_hit, input bit noisy);
    int          k;
    logic [63:0] pck, ev;
    bit          to;
    exp_t        e;
    @(negedge CLK);
    predict(base, step, endp, k, pck, to);
    ev         = use_hit ? (pck ^ salt) : expv;
    e.done_cyc = cyc + 1 + RC + k;
    e.to       = to;
    e.pass     = !to && ((pck ^ salt) == ev);
    e.spc      = base;
    m_rc       = sat8(m_rc + 1);
    m_pc       = sat8(m_pc + (e.pass ? 1 : 0));
    e.rc       = m_rc;
    e.pc       = m_pc;
    sbq.push_back(e);
    cur_base = base; cur_step = step; cur_salt = salt;
    start_pc_in = base; end_pc = endp; expected = ev; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!busy) break;
      if (noisy) begin
        start       = 1'($urandom_range(0, 1));
        start_pc_in = 64'h100;
        end_pc      = {32'h0, $urandom};
        expected    = {$urandom, $urandom};
      end
      @(negedge CLK);
    end
    if (busy) check("run_bound_busy", busy, 1'b0);
    start = 1'b0;
  endtask

  exp_t pend;
  bit   cnt_pend  = 1'b0;
  int   hold_seen = 0;

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (reset) begin
        hold_seen = 0;
        cnt_pend  = 1'b0;
      end else begin
        if (proc_reset) hold_seen++;
        if (cnt_pend) begin
          check("done_width", done, 1'b0);
          check("busy_after", busy, 1'b0);
          check("run_count", run_count, pend.rc);
          check("pass_count", pass_count, pend.pc);
          cnt_pend = 1'b0;
        end else if (done) begin
          if (sbq.size() == 0) begin
            check("spurious_done", done, 1'b0);
          end else begin
            e = sbq.pop_front();
            check("done_cycle", cyc, e.done_cyc);
            check("pass", pass, e.pass);
            check("timeout", timeout, e.to);
            check("startpc", startpc, e.spc);
            check("hold_len", hold_seen, RC);
            hold_seen = 0;
            pend      = e;
            cnt_pend  = 1'b1;
          end
        end else if (sbq.size() > 0 && cyc > sbq[0].done_cyc) begin
          check("done_missing", done, 1'b1);
          void'(sbq.pop_front());
          hold_seen = 0;
        end
      end
    end
  end

  initial begin : guard
    #900000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin : driver
    logic [63:0]     b, s, en;
    int              sel;
    longint unsigned n0;
    reset = 1'b1; start = 1'b0;
    start_pc_in = '0; end_pc = '0; expected = '0;
    #3;
    check("rst_proc_reset", proc_reset, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_startpc", startpc, 64'h0);
    check("rst_counts", {run_count, pass_count}, 16'h0);
    repeat (2) @(negedge CLK);
    #2 reset = 1'b0;
    @(negedge CLK);
    check("idle_proc_reset", proc_reset, 1'b0);
    check("idle_busy", busy, 1'b0);

    // Directed runs: pass, mismatch, stuck PC, watchdog boundary, unsigned compare.
    run_one(64'h0, 64'd4, 64'h30, 64'hF, 64'h30 ^ 64'hF, 1'b0, 1'b0);
    run_one(64'h0, 64'd4, 64'h30, 64'hF, 64'h30 ^ 64'hE, 1'b0, 1'b0);
    run_one(64'h8, 64'd0, 64'h30, 64'hF, 64'h0, 1'b0, 1'b0);
    run_one(64'h0, 64'd1, 64'hFF, 64'h0, 64'h5A5A, 1'b1, 1'b0);
    run_one(64'h0, 64'd1, 64'h100, 64'h0, 64'h5A5A, 1'b1, 1'b0);
    run_one(64'h8000_0000_0000_0000, 64'd0, 64'h30, 64'h0, 64'h77, 1'b1, 1'b0);
    run_one(64'h0, 64'd4, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0, 64'h0, 1'b1, 1'b0);
    run_one(64'h40, 64'd4, 64'h80, 64'h0, 64'h3, 1'b1, 1'b1);

    for (int i = 0; i < 60; i++) begin
      b   = {32'h0, $urandom};
      sel = $urandom_range(0, 4);
      s   = (sel == 0) ? 64'd0 : (sel == 1) ? 64'd1 : (sel == 2) ? 64'd4 :
            (sel == 3) ? 64'd8 : 64'($urandom_range(1, 64));
      en  = b + 64'($urandom_range(0, 1100));
      if ($urandom_range(0, 9) == 0) en = b - 64'($urandom_range(0, 50));
      run_one(b, s, en, {$urandom, $urandom}, {$urandom, $urandom},
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Enough immediate passes to drive both counters into saturation.
    for (int i = 0; i < 260; i++)
      run_one({32'h0, $urandom}, 64'd4, 64'h0, 64'h0, {$urandom, $urandom}, 1'b1, 1'b0);

    // Abort a run with reset while the watchdog reads 5.
    @(negedge CLK);
    cur_base = 64'h0; cur_step = 64'd4; cur_salt = 64'h0;
    start_pc_in = 64'h0; end_pc = 64'h1000; expected = 64'h0; start = 1'b1;
    n0 = cyc;
    @(negedge CLK);
    start = 1'b0;
    while (cyc < n0 + 8) @(negedge CLK);
    #2 reset = 1'b1;
    sbq.delete();
    m_rc = 0; m_pc = 0;
    #1;
    check("abort_proc_reset", proc_reset, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_pass_to", {pass, timeout}, 2'b00);
    check("abort_startpc", startpc, 64'h0);
    check("abort_counts", {run_count, pass_count}, 16'h0);
    @(negedge CLK);
    check("abort_hold_proc_reset", proc_reset, 1'b1);
    #2 reset = 1'b0;
    repeat (3) @(negedge CLK);
    check("post_abort_proc_reset", proc_reset, 1'b0);
    check("post_abort_busy", busy, 1'b0);

    run_one(64'h200, 64'd4, 64'h230, 64'h0, 64'h1234, 1'b1, 1'b1);
    run_one(64'h0, 64'd0, 64'h30, 64'h0, 64'h0, 1'b0, 1'b0);
    repeat (4) @(negedge CLK);
    check("queue_drained", 64'(sbq.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/proc_run_controller.md
PROC_RUN_CONTROLLER -- requirements
Module: proc_run_controller

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 2: processor reset hold length in cycles (min 1).
REQ-002 SHALL have parameter WATCHDOG_MAX, default 16'h00FF: last RUN-cycle watchdog value before timeout.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request a run; sampled only in IDLE.
REQ-006 SHALL have port start_pc_in  input  64  program entry PC for the run.
REQ-007 SHALL have port end_pc  input  64  run ends when currentpc >= this value.
REQ-008 SHALL have port expected  input  64  expected MemtoRegOut at end of run.
REQ-009 SHALL have port currentpc  input  64  processor current PC.
REQ-010 SHALL have port MemtoRegOut  input  64  processor write-back value.
REQ-011 SHALL have port proc_reset  output  1  drives processor reset.
REQ-012 SHALL have port startpc  output  64  drives processor start PC.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port done  output  1  one-cycle end-of-run pulse.
REQ-015 SHALL have port pass  output  1  result of the last run; valid from done until the next start.
REQ-016 SHALL have port timeout  output  1  last run ended by watchdog; valid from done until the next start.
REQ-017 SHALL have port run_count  output  8  number of completed runs, saturating at 255.
REQ-018 SHALL have port pass_count  output  8  number of passed runs, saturating at 255.

Function
REQ-019 SHALL implement the FSM states IDLE, HOLD, RUN and DONE.
REQ-020 In IDLE with start=1, SHALL capture start_pc_in into startpc, and end_pc and expected into internal registers, clear pass and timeout, clear the hold counter, and enter HOLD.
REQ-021 SHALL ignore start in HOLD, RUN and DONE, and SHALL ignore changes to start_pc_in, end_pc and expected after capture.
REQ-022 proc_reset SHALL equal (reset | state==HOLD), so the processor is held in reset during controller reset.
REQ-023 SHALL remain in HOLD for exactly RESET_CYCLES cycles, then enter RUN with the 16-bit watchdog cleared to 0.
REQ-024 In RUN, each cycle SHALL compare currentpc >= captured end_pc as unsigned 64-bit values.
REQ-025 On a RUN cycle where the compare is true, SHALL register pass = (MemtoRegOut == captured expected), set timeout=0, and enter DONE.
REQ-026 On a RUN cycle where the compare is false and watchdog == WATCHDOG_MAX, SHALL set timeout=1 and pass=0, and enter DONE.
REQ-027 On any other RUN cycle, SHALL increment the watchdog by 1.
REQ-028 SHALL give end-PC detection priority over timeout when both occur in the same cycle.
REQ-029 In DONE, SHALL assert done for exactly one cycle, increment run_count, increment pass_count if pass=1, and return to IDLE.
REQ-030 run_count and pass_count SHALL saturate at 8'hFF and never wrap.
REQ-031 startpc SHALL hold its captured value until the next accepted start.

Reset
REQ-032 reset=1 SHALL immediately force state=IDLE, startpc=0, busy=0, done=0, pass=0, timeout=0, run_count=0, pass_count=0, watchdog=0 and hold counter=0, independent of CLK.
REQ-033 Reset asserted mid-HOLD or mid-RUN SHALL abort the run with no done pulse and no counter update.
REQ-034 After reset deasserts, proc_reset SHALL be 0 until the next accepted start.

Verification
REQ-035 Scenario: start_pc_in=0, end_pc=0x30, expected=0xF; currentpc starts at 0 on RUN entry and steps by 4 each cycle; MemtoRegOut=0xF at pc 0x30 -> proc_reset high exactly 2 cycles, startpc=0, done one cycle after the 13th RUN cycle, pass=1, timeout=0, run_count=1, pass_count=1.
REQ-036 Scenario: same stimulus with MemtoRegOut=0xE at pc 0x30 -> done, pass=0, timeout=0, run_count=2, pass_count=1.
REQ-037 Scenario: currentpc stuck at 0x8, end_pc=0x30 -> timeout=1 and pass=0 after 256 RUN cycles, done pulses once, pass_count unchanged.
REQ-038 Scenario: currentpc reaches 0x30 on the RUN cycle where watchdog=0xFF -> timeout=0 and pass evaluated.
REQ-039 Scenario: reset pulsed during RUN at watchdog=5 -> outputs at reset values within the same cycle, proc_reset=1 while reset is high, no done pulse; a following start runs normally.
REQ-040 Scenario: start pulsed during HOLD, RUN and DONE with start_pc_in=0x100 -> ignored; startpc is unchanged and exactly one done pulse occurs.
